// File: rtl/vlc_bit_packer_pkg.sv
// vlc_bit_packer_pkg: shared widths and FSM encoding for the bit packer
package vlc_bit_packer_pkg;
  localparam int AW = 64;
  localparam int WW = 32;
  localparam int NW = 7;
  typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} state_t;
endpackage

// File: rtl/vlc_bit_insert.sv
// vlc_bit_insert: merges a masked, right-aligned code into acc just below the first pos valid bits
module vlc_bit_insert import vlc_bit_packer_pkg::*; #(
  parameter int CW = 24,
  parameter int LW = 5
) (
  input  logic [AW-1:0] acc_in,
  input  logic [NW-1:0] pos,
  input  logic [CW-1:0] code,
  input  logic [LW-1:0] len,
  output logic [LW-1:0] eff_len,
  output logic [AW-1:0] acc_out
);
  logic [CW-1:0] mask;
  logic [NW-1:0] sh;
  // oversize lengths count as empty; only the low eff_len code bits survive the mask
  always_comb begin
    eff_len = (32'(len) > CW) ? '0 : len;
    mask = ~({CW{1'b1}} << eff_len);
    sh = NW'(AW) - pos - NW'(eff_len);
    acc_out = acc_in | ({{(AW-CW){1'b0}}, code & mask} << sh);
  end
endmodule

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer: packs variable-length codes into 32-bit words with flush/zero-pad
module vlc_bit_packer import vlc_bit_packer_pkg::*; #(
  parameter int CW = 24,
  parameter int LW = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_empty,
  input  logic [LW+CW-1:0] in_dat,
  output logic             in_re,
  input  logic             out_full,
  output logic             out_we,
  output logic [WW-1:0]    out_dat,
  input  logic             flush,
  output logic             flush_done
);
  state_t state, state_nxt;
  logic [NW-1:0] cnt, cnt_nxt, base_cnt;
  logic [AW-1:0] acc, acc_nxt, base_acc, merged;
  logic [LW-1:0] eff_len;
  assign out_dat = acc[AW-1 -: WW];
  vlc_bit_insert #(.CW(CW), .LW(LW)) u_insert (
    .acc_in(base_acc),
    .pos(base_cnt),
    .code(in_dat[CW-1:0]),
    .len(in_dat[LW+CW-1:CW]),
    .eff_len(eff_len),
    .acc_out(merged)
  );
  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= RUN;
    else state <= state_nxt;
  end
  // flush sequencing: drain full words, pad any remainder, then pulse done
  always_comb begin
    state_nxt = (state == RUN) ? (flush ? DRAIN : RUN)
              : (state == DRAIN) ? ((cnt >= NW'(WW)) ? DRAIN : (cnt != '0) ? PAD : DONE)
              : (state == PAD) ? (out_we ? DONE : PAD)
              : RUN;
  end
  // handshake strobes depend only on registered state and the FIFO flags
  always_comb begin
    out_we = (cnt >= NW'(WW)) & ~out_full;
    in_re = ~clr & (state == RUN) & ~in_empty & ((cnt < NW'(WW)) | out_we);
    flush_done = (state == DONE);
  end
  // emit shifts the top word out first so a same-cycle take lands below the leftover bits
  always_comb begin
    base_cnt = out_we ? cnt - NW'(WW) : cnt;
    base_acc = out_we ? acc << WW : acc;
    cnt_nxt = (state == DONE) ? '0
            : ((state == DRAIN) && (cnt < NW'(WW)) && (cnt != '0)) ? NW'(WW)
            : in_re ? base_cnt + NW'(eff_len)
            : base_cnt;
    acc_nxt = (state == DONE) ? '0 : in_re ? merged : base_acc;
  end
  // accumulator and bit count; bits below the valid region are always zero, so padding is free
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_vlc_bit_packer.sv
// tb_vlc_bit_packer: directed scoreboard bench for vlc_bit_packer
module tb_vlc_bit_packer;
  import vlc_bit_packer_pkg::*;
  localparam int CW = 24;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic in_empty = 1'b1;
  logic [LW+CW-1:0] in_dat = '0;
  logic out_full = 1'b0;
  logic flush = 1'b0;
  logic in_re, out_we, flush_done;
  logic [31:0] out_dat;
  int errors = 0;
  int checks = 0;
  logic [LW+CW-1:0] fifo[$];
  logic [31:0] exp_q[$];

  vlc_bit_packer #(.CW(CW), .LW(LW)) dut (
    .clk(clk),
    .clr(clr),
    .in_empty(in_empty),
    .in_dat(in_dat),
    .in_re(in_re),
    .out_full(out_full),
    .out_we(out_we),
    .out_dat(out_dat),
    .flush(flush),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // upstream FIFO model: pops on a take, presents the head shortly after the edge
  initial forever begin
    @(posedge clk);
    if (in_re && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    in_empty = (fifo.size() == 0);
    in_dat = (fifo.size() == 0) ? '0 : fifo[0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int len, input logic [CW-1:0] code);
    fifo.push_back({LW'(len), code});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_flush(output int t_we, output int t_done);
    bit done = 0;
    t_we = -1;
    t_done = -1;
    flush = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i == 1) flush = 1'b0;
      #1;
      if (out_we && t_we < 0) t_we = i;
      if (flush_done) begin
        t_done = i;
        done = 1;
      end
      @(negedge clk);
    end
    flush = 1'b0;
    check("flush_done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int t4, tw, takes, seen, a, b;
    fork
      forever begin
        @(negedge clk);
        #2;
        if (out_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected no write", out_dat);
          end else check("word", 64'(out_dat), 64'(exp_q.pop_front()));
        end
      end
    join_none
    // reset state with an entry already waiting upstream
    for (int i = 0; i < 4; i++) put(8, 24'hA5);
    exp_q.push_back(32'hA5A5A5A5);
    cyc(2);
    #1;
    check("rst_cnt", 64'(dut.cnt), 64'd0);
    check("rst_in_re", 64'(in_re), 64'd0);
    check("rst_out_we", 64'(out_we), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    // four bytes -> one word, one cycle after the last take
    t4 = -100;
    tw = -100;
    takes = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (in_re) begin
        takes++;
        if (takes == 4) t4 = i;
      end
      if (out_we && tw < 0) tw = i;
      @(negedge clk);
    end
    check("latency", 64'(tw - t4), 64'd1);
    // word crossing plus zero-padded flush
    put(24, 24'hFFFFFF);
    put(16, 24'h0);
    exp_q.push_back(32'hFFFFFF00);
    cyc(6);
    check("cnt_after_cross", 64'(dut.cnt), 64'd8);
    exp_q.push_back(32'h00000000);
    do_flush(a, b);
    check("cnt_after_flush", 64'(dut.cnt), 64'd0);
    // short code flush, done one cycle after the padded word
    put(3, 24'h5);
    exp_q.push_back(32'hA0000000);
    cyc(4);
    do_flush(a, b);
    check("done_after_we", 64'(b - a), 64'd1);
    check("cnt_after_short", 64'(dut.cnt), 64'd0);
    // back-pressure holds cnt=40
    out_full = 1'b1;
    put(24, 24'hABCDEF);
    put(16, 24'h1234);
    put(8, 24'h56);
    exp_q.push_back(32'hABCDEF12);
    exp_q.push_back(32'h34560000);
    cyc(5);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("full_in_re", 64'(in_re), 64'd0);
      check("full_dat", 64'(out_dat), 64'hABCDEF12);
      check("full_cnt", 64'(dut.cnt), 64'd40);
      @(negedge clk);
    end
    out_full = 1'b0;
    #1;
    check("release_we", 64'(out_we), 64'd1);
    check("release_in_re", 64'(in_re), 64'd1);
    cyc(3);
    check("cnt_after_release", 64'(dut.cnt), 64'd16);
    do_flush(a, b);
    // zero-length and oversize entries add nothing; empty flush is quick
    put(0, 24'hFFFFFF);
    put(30, 24'hFFFFFF);
    cyc(4);
    check("null_consumed", 64'(fifo.size()), 64'd0);
    check("null_cnt", 64'(dut.cnt), 64'd0);
    do_flush(a, b);
    check("empty_flush_we", 64'(a), 64'hFFFFFFFFFFFFFFFF);
    check("empty_flush_done", 64'(b), 64'd2);
    // clr in the middle of a flush discards pending bits
    put(17, 24'h1ABCD);
    cyc(4);
    check("pre_clr_cnt", 64'(dut.cnt), 64'd17);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("pre_clr_state", 64'(dut.state), 64'(DRAIN));
    clr = 1'b1;
    #1;
    check("clr_cnt", 64'(dut.cnt), 64'd0);
    check("clr_state", 64'(dut.state), 64'(RUN));
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_we || flush_done) seen++;
      @(negedge clk);
    end
    check("post_clr_quiet", 64'(seen), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
